// File: rtl/pong_ball_engine.sv
// rtl/pong_ball_engine.sv - Pong ball kinematics, scoring and ball-pixel engine
//
// Purpose: moves one ball over a parametrised screen, bounces it off the
// top/bottom walls and two paddles (three-zone deflection), keeps score,
// runs the IDLE/SERVE/PLAY/WIN match flow and flags ball pixels for the
// colour mux one cycle after the VGA coordinates are presented.
//
// Ports:
//   clk_in        pixel clock
//   i_rst_n       synchronous active-low reset
//   i_start       level; starts a match from IDLE or WIN
//   o_active      VGA active-area flag
//   o_x, o_y      current pixel coordinates from the timing generator
//   pos_yBarra1/2 top row of the left/right paddle
//   pointPlayer1/2 one-cycle pulse when that player scores
//   score1/2      saturating score counters
//   winner        00 none, 01 player 1, 10 player 2
//   ball_x/ball_y ball top-left corner
//   color         registered ball-pixel flag
module pong_ball_engine #(
  parameter int          H_RES        = 640,
  parameter int          V_RES        = 480,
  parameter int          BALL_W       = 8,
  parameter int          BALL_H       = 8,
  parameter int          PAD1_X       = 10,
  parameter int          PAD2_X       = 610,
  parameter int          PAD_W        = 10,
  parameter int          PAD_H        = 90,
  parameter int          SPEED_X      = 2,
  parameter int          SPEED_Y      = 2,
  parameter int          FRAME_DIV    = 1,
  parameter int          SERVE_FRAMES = 60,
  parameter int          WIN_SCORE    = 9,
  parameter int          SCORE_W      = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk_in,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               o_active,
  input  logic [9:0]         o_x,
  input  logic [8:0]         o_y,
  input  logic [8:0]         pos_yBarra1,
  input  logic [8:0]         pos_yBarra2,
  output logic               pointPlayer1,
  output logic               pointPlayer2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [9:0]         ball_x,
  output logic [8:0]         ball_y,
  output logic               color
);

  // Signed working width: wide enough that ball +/- speed never wraps.
  localparam int SW     = 12;
  localparam int SCNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0] BX0      = 10'((H_RES - BALL_W) / 2);
  localparam logic [8:0] BY0      = 9'((V_RES - BALL_H) / 2);
  localparam logic [8:0] BY_MAX   = 9'(V_RES - BALL_H);
  localparam logic [9:0] BX_L_HIT = 10'(PAD1_X + PAD_W);
  localparam logic [9:0] BX_R_HIT = 10'(PAD2_X - BALL_W);

  localparam logic signed [SW-1:0] SX     = SW'(SPEED_X);
  localparam logic signed [SW-1:0] SY     = SW'(SPEED_Y);
  localparam logic signed [SW-1:0] ZERO   = '0;
  localparam logic signed [SW-1:0] Y_MAX  = SW'(V_RES - BALL_H);
  localparam logic signed [SW-1:0] X_MAX  = SW'(H_RES - BALL_W);
  localparam logic signed [SW-1:0] L_X    = SW'(PAD1_X);
  localparam logic signed [SW-1:0] L_EDGE = SW'(PAD1_X + PAD_W);
  localparam logic signed [SW-1:0] R_EDGE = SW'(PAD2_X - BALL_W);
  localparam logic signed [SW-1:0] R_BACK = SW'(PAD2_X + PAD_W - BALL_W);
  localparam logic signed [SW-1:0] HALF_H = SW'(BALL_H / 2);
  localparam logic signed [SW-1:0] ZONE1  = SW'(PAD_H / 3);
  localparam logic signed [SW-1:0] ZONE2  = SW'((2 * PAD_H) / 3);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
  localparam logic [SCNT_W-1:0]  SCNT_LAST = SCNT_W'(SERVE_FRAMES - 1);
  localparam logic [7:0]         FDIV_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_WIN} state_t;

  state_t                state, state_nxt;
  logic signed [SW-1:0]  dx, dy, dx_nxt, dy_nxt;
  logic [9:0]            bx_nxt;
  logic [8:0]            by_nxt;
  logic [SCORE_W-1:0]    s1_nxt, s2_nxt, s1_inc, s2_inc;
  logic [1:0]            win_nxt;
  logic                  p1_nxt, p2_nxt, color_nxt;
  logic [15:0]           lfsr;
  logic [7:0]            frame_cnt;
  logic [SCNT_W-1:0]     serve_cnt, scnt_nxt;
  logic [8:0]            wall_y;
  logic signed [SW-1:0]  wall_dy;

  logic                  frame_tick, upd;
  logic signed [SW-1:0]  bx_s, by_s, nx, ny, rel1, rel2;
  logic [10:0]           by_w, pad1_w, pad2_w;
  logic                  ov1, ov2, hit1, hit2, in_x, in_y;

  assign frame_tick = (o_x == 10'(H_RES - 1)) && (o_y == 9'(V_RES - 1));
  assign upd        = frame_tick && (frame_cnt == FDIV_LAST);

  assign bx_s = $signed({2'b00, ball_x});
  assign by_s = $signed({3'b000, ball_y});
  assign nx   = bx_s + dx;
  assign ny   = by_s + dy;

  // Row overlap of the ball's current rows with each paddle.
  assign by_w   = {2'b00, ball_y};
  assign pad1_w = {2'b00, pos_yBarra1};
  assign pad2_w = {2'b00, pos_yBarra2};
  assign ov1    = (by_w < pad1_w + 11'(PAD_H)) && (by_w + 11'(BALL_H) > pad1_w);
  assign ov2    = (by_w < pad2_w + 11'(PAD_H)) && (by_w + 11'(BALL_H) > pad2_w);

  // Ball centre row relative to the paddle top; negative or past the
  // paddle falls naturally into the top or bottom zone.
  assign rel1 = by_s + HALF_H - $signed({3'b000, pos_yBarra1});
  assign rel2 = by_s + HALF_H - $signed({3'b000, pos_yBarra2});

  assign hit1 = dx[SW-1] && (nx <= L_EDGE) && (bx_s >= L_X) && ov1;
  assign hit2 = !dx[SW-1] && (dx != ZERO) && (nx >= R_EDGE) && (bx_s <= R_BACK) && ov2;

  assign s1_inc = (score1 == SCORE_MAX) ? score1 : score1 + 1'b1;
  assign s2_inc = (score2 == SCORE_MAX) ? score2 : score2 + 1'b1;

  assign in_x = (o_x >= ball_x) && ({1'b0, o_x} < ({1'b0, ball_x} + 11'(BALL_W)));
  assign in_y = (o_y >= ball_y) && ({1'b0, o_y} < ({1'b0, ball_y} + 10'(BALL_H)));
  assign color_nxt = o_active && in_x && in_y;

  function automatic logic signed [SW-1:0] zone_dy(input logic signed [SW-1:0] rel,
                                                   input logic signed [SW-1:0] dy_in);
    if (rel < ZONE1)       zone_dy = -SY;
    else if (rel >= ZONE2) zone_dy = SY;
    else                   zone_dy = dy_in;
  endfunction

  always_comb begin
    state_nxt = state;
    bx_nxt    = ball_x;
    by_nxt    = ball_y;
    dx_nxt    = dx;
    dy_nxt    = dy;
    s1_nxt    = score1;
    s2_nxt    = score2;
    win_nxt   = winner;
    p1_nxt    = 1'b0;
    p2_nxt    = 1'b0;
    scnt_nxt  = serve_cnt;
    wall_y    = ny[8:0];
    wall_dy   = dy;

    case (state)
      S_IDLE: begin
        bx_nxt = BX0;
        by_nxt = BY0;
        if (i_start) begin
          state_nxt = S_SERVE;
          scnt_nxt  = '0;
        end
      end

      S_SERVE: begin
        bx_nxt = BX0;
        by_nxt = BY0;
        if (frame_tick) begin
          if (serve_cnt == SCNT_LAST) begin
            state_nxt = S_PLAY;
            scnt_nxt  = '0;
            dy_nxt    = lfsr[0] ? -SY : SY;
          end else begin
            scnt_nxt = serve_cnt + 1'b1;
          end
        end
      end

      S_PLAY: begin
        if (upd) begin
          if (ny[SW-1]) begin
            wall_y  = '0;
            wall_dy = -dy;
          end else if (ny > Y_MAX) begin
            wall_y  = BY_MAX;
            wall_dy = -dy;
          end
          by_nxt = wall_y;
          dy_nxt = wall_dy;

          // Paddle hits win over a score on the same update; the zone
          // deflection is applied on top of any wall bounce.
          if (hit1) begin
            bx_nxt = BX_L_HIT;
            dx_nxt = SX;
            dy_nxt = zone_dy(rel1, wall_dy);
          end else if (hit2) begin
            bx_nxt = BX_R_HIT;
            dx_nxt = -SX;
            dy_nxt = zone_dy(rel2, wall_dy);
          end else if (nx <= ZERO) begin
            p2_nxt = 1'b1;
            s2_nxt = s2_inc;
            dx_nxt = -SX;
            dy_nxt = ZERO;
            bx_nxt = BX0;
            by_nxt = BY0;
            scnt_nxt = '0;
            if (s2_inc == WIN_S) begin
              state_nxt = S_WIN;
              win_nxt   = 2'b10;
            end else begin
              state_nxt = S_SERVE;
            end
          end else if (nx >= X_MAX) begin
            p1_nxt = 1'b1;
            s1_nxt = s1_inc;
            dx_nxt = SX;
            dy_nxt = ZERO;
            bx_nxt = BX0;
            by_nxt = BY0;
            scnt_nxt = '0;
            if (s1_inc == WIN_S) begin
              state_nxt = S_WIN;
              win_nxt   = 2'b01;
            end else begin
              state_nxt = S_SERVE;
            end
          end else begin
            bx_nxt = nx[9:0];
          end
        end
      end

      S_WIN: begin
        bx_nxt = BX0;
        by_nxt = BY0;
        if (i_start) begin
          s1_nxt    = '0;
          s2_nxt    = '0;
          win_nxt   = 2'b00;
          scnt_nxt  = '0;
          state_nxt = S_SERVE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      ball_x       <= BX0;
      ball_y       <= BY0;
      dx           <= SX;
      dy           <= ZERO;
      score1       <= '0;
      score2       <= '0;
      winner       <= 2'b00;
      pointPlayer1 <= 1'b0;
      pointPlayer2 <= 1'b0;
      color        <= 1'b0;
      lfsr         <= LFSR_SEED;
      frame_cnt    <= '0;
      serve_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      ball_x       <= bx_nxt;
      ball_y       <= by_nxt;
      dx           <= dx_nxt;
      dy           <= dy_nxt;
      score1       <= s1_nxt;
      score2       <= s2_nxt;
      winner       <= win_nxt;
      pointPlayer1 <= p1_nxt;
      pointPlayer2 <= p2_nxt;
      color        <= color_nxt;
      // Galois LFSR, taps 16,14,13,11.
      lfsr         <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      serve_cnt    <= scnt_nxt;
      if (frame_tick)
        frame_cnt <= (frame_cnt == FDIV_LAST) ? 8'd0 : frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb/tb_pong_ball_engine.sv - directed self-checking bench for pong_ball_engine
module tb_pong_ball_engine;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int SERVE_FRAMES = 60;
  localparam int BX0          = 316;
  localparam int BY0          = 236;
  localparam int YMAX         = 472;
  localparam int OFF          = 500;

  logic       clk_in   = 1'b0;
  logic       i_rst_n  = 1'b0;
  logic       i_start  = 1'b0;
  logic       o_active = 1'b0;
  logic [9:0] o_x = '0;
  logic [8:0] o_y = '0;
  logic [8:0] pos_yBarra1 = 9'(OFF);
  logic [8:0] pos_yBarra2 = 9'(OFF);
  logic       pointPlayer1, pointPlayer2;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       color;

  pong_ball_engine #(.WIN_SCORE(2)) dut (
    .clk_in(clk_in), .i_rst_n(i_rst_n), .i_start(i_start),
    .o_active(o_active), .o_x(o_x), .o_y(o_y),
    .pos_yBarra1(pos_yBarra1), .pos_yBarra2(pos_yBarra2),
    .pointPlayer1(pointPlayer1), .pointPlayer2(pointPlayer2),
    .score1(score1), .score2(score2), .winner(winner),
    .ball_x(ball_x), .ball_y(ball_y), .color(color)
  );

  always #5 clk_in = ~clk_in;

  logic [15:0] tb_lfsr;
  always @(posedge clk_in)
    tb_lfsr <= !i_rst_n ? 16'hACE1 : ({1'b0, tb_lfsr[15:1]} ^ (tb_lfsr[0] ? 16'hB400 : 16'h0000));

  int n_checks = 0;
  int n_errors = 0;
  int mx, my, mdx, mdy;
  logic p1_a, p1_b, p2_a, p2_b;

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One frame tick followed by one ordinary cycle; called just after a negedge.
  task automatic tick();
    o_x = 10'(H_RES - 1); o_y = 9'(V_RES - 1); o_active = 1'b0;
    @(negedge clk_in);
    o_x = '0; o_y = '0;
    p1_a = pointPlayer1; p2_a = pointPlayer2;
    @(negedge clk_in);
    p1_b = pointPlayer1; p2_b = pointPlayer2;
  endtask

  task automatic model_fly();
    int ny;
    mx = mx + mdx;
    ny = my + mdy;
    if (ny < 0)         begin my = 0;    mdy = -mdy; end
    else if (ny > YMAX) begin my = YMAX; mdy = -mdy; end
    else                my = ny;
  endtask

  task automatic fly(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      model_fly();
    end
  endtask

  task automatic check_pos(input string tag);
    expect_eq(tag, 32'(ball_x), mx);
    expect_eq(tag, 32'(ball_y), my);
  endtask

  // zone: -1 top (dy=-2), 0 middle (dy kept), +1 bottom (dy=+2)
  task automatic hit(input int left, input int pad, input int zone);
    if (left != 0) pos_yBarra1 = 9'(pad); else pos_yBarra2 = 9'(pad);
    tick();
    pos_yBarra1 = 9'(OFF); pos_yBarra2 = 9'(OFF);
    model_fly();
    mx  = (left != 0) ? 20 : 602;
    mdx = (left != 0) ? 2 : -2;
    if (zone != 0) mdy = 2 * zone;
    check_pos("hit_pos");
    fly(1);
    check_pos("after_hit_pos");
  endtask

  task automatic press_start();
    i_start = 1'b1;
    @(negedge clk_in);
    i_start = 1'b0;
  endtask

  task automatic serve(output int s);
    logic moved;
    moved = 1'b0;
    s = 0;
    for (int i = 1; i <= SERVE_FRAMES; i++) begin
      if (i == SERVE_FRAMES) s = tb_lfsr[0] ? -2 : 2;
      tick();
      if (ball_x != 10'(BX0) || ball_y != 9'(BY0)) moved = 1'b1;
    end
    expect_eq("serve_static", 32'(moved), 0);
    mx = BX0; my = BY0; mdy = s;
  endtask

  int cx[6] = '{316, 315, 323, 324, 320, 320};
  int cy[6] = '{236, 236, 243, 243, 244, 240};
  int ca[6] = '{1, 1, 1, 1, 1, 0};
  int cc[6] = '{1, 0, 1, 0, 0, 0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    int zone;
    o_x = 10'd100; o_y = 9'd50; o_active = 1'b1;
    repeat (2) @(negedge clk_in);
    expect_eq("rst_ball_x", 32'(ball_x), BX0);
    expect_eq("rst_ball_y", 32'(ball_y), BY0);
    expect_eq("rst_score1", 32'(score1), 0);
    expect_eq("rst_score2", 32'(score2), 0);
    expect_eq("rst_winner", 32'(winner), 0);
    expect_eq("rst_color", 32'(color), 0);
    expect_eq("rst_points", 32'({pointPlayer1, pointPlayer2}), 0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      o_x = 10'(cx[i]); o_y = 9'(cy[i]); o_active = (ca[i] != 0);
      @(negedge clk_in);
      expect_eq("color", 32'(color), cc[i]);
    end
    o_active = 1'b0;

    repeat (5) tick();
    expect_eq("idle_ball_x", 32'(ball_x), BX0);
    expect_eq("idle_ball_y", 32'(ball_y), BY0);

    // Rally 1: free flight, wall bounce, right-side miss.
    press_start();
    serve(s);
    mdx = 2;
    fly(1);
    expect_eq("first_upd_x", 32'(ball_x), 318);
    expect_eq("first_upd_y", 32'(ball_y), 236 + s);
    fly(117);
    expect_eq("wall_k118_x", 32'(ball_x), 552);
    expect_eq("wall_k118_y", 32'(ball_y), (s > 0) ? 472 : 0);
    fly(1);
    expect_eq("wall_k119_y", 32'(ball_y), (s > 0) ? 472 : 0);
    fly(1);
    expect_eq("wall_k120_y", 32'(ball_y), (s > 0) ? 470 : 2);
    fly(37);
    expect_eq("pre_point_x", 32'(ball_x), 630);
    tick();
    expect_eq("p1_pulse", 32'(p1_a), 1);
    expect_eq("p1_pulse_end", 32'(p1_b), 0);
    expect_eq("p2_quiet", 32'(p2_a), 0);
    expect_eq("score1_one", 32'(score1), 1);
    expect_eq("recentre_x", 32'(ball_x), BX0);
    expect_eq("recentre_y", 32'(ball_y), BY0);

    // Rally 2: paddle zones on both sides, then the winning miss.
    serve(s);
    mdx = 2;
    fly(1);
    expect_eq("serve2_x", 32'(ball_x), 318);
    fly(141);
    check_pos("r2_pre_rhit");
    hit(0, my, -1);
    fly(289);
    check_pos("r2_pre_lhit_top");
    hit(1, my, -1);
    fly(289);
    check_pos("r2_pre_rhit2");
    zone = (my >= 61) ? 1 : -1;
    hit(0, (my >= 61) ? my - 61 : my, zone);
    fly(289);
    check_pos("r2_pre_lhit_mid");
    zone = (my >= 41) ? 0 : -1;
    hit(1, (my >= 41) ? my - 41 : my, zone);
    fly(304);
    expect_eq("r2_pre_point_x", 32'(ball_x), 630);
    tick();
    expect_eq("p1_win_pulse", 32'(p1_a), 1);
    expect_eq("score1_two", 32'(score1), 2);
    expect_eq("winner_p1", 32'(winner), 1);

    repeat (5) tick();
    expect_eq("win_hold_score1", 32'(score1), 2);
    expect_eq("win_hold_winner", 32'(winner), 1);
    expect_eq("win_frozen_x", 32'(ball_x), BX0);
    expect_eq("win_frozen_y", 32'(ball_y), BY0);
    expect_eq("win_no_pulse", 32'(p1_a | p1_b), 0);

    press_start();
    expect_eq("restart_score1", 32'(score1), 0);
    expect_eq("restart_score2", 32'(score2), 0);
    expect_eq("restart_winner", 32'(winner), 0);

    // Rally 3: right paddle return, left-side miss.
    serve(s);
    mdx = 2;
    fly(1);
    expect_eq("serve3_x", 32'(ball_x), 318);
    fly(141);
    hit(0, my, -1);
    fly(299);
    expect_eq("r3_pre_point_x", 32'(ball_x), 2);
    tick();
    expect_eq("p2_pulse", 32'(p2_a), 1);
    expect_eq("p2_pulse_end", 32'(p2_b), 0);
    expect_eq("score2_one", 32'(score2), 1);
    expect_eq("score1_zero", 32'(score1), 0);
    expect_eq("r3_recentre_x", 32'(ball_x), BX0);

    serve(s);
    fly(1);
    expect_eq("serve_toward_p1_x", 32'(ball_x), 314);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
